gan_layer_sequencer: RTL and testbench
======================================

Name: gan_layer_sequencer

Overview:
- Layer-level scheduler sitting above the conv2d control unit.
- Holds a small table of layer configurations and runs each layer's output channels one at a time: per channel it starts a conv pass, waits for the conv done pulse, then triggers the output writeback.
- Drives the conv CU's size selects, its kernel-load request and its active-low control reset, so the PS only issues one start per network pass instead of one per output channel.

Parameters:
- MAX_LAYERS, 8, depth of layer config table (power of two).
- LAYER_W, 3, log2(MAX_LAYERS).
- WDOG_CYCLES, 2^20, watchdog limit per wait state (used only with SEQ_WATCHDOG_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  config table write strobe
- cfg_addr  in  LAYER_W  table entry index
- cfg_data  in  16  entry: [1:0] CHANNEL_SIZE_choose, [4:2] IMAGE_SIZE_choose, [13:5] out_ch_m1, [15:14] reserved
- num_layers  in  LAYER_W+1  layers to run (0..MAX_LAYERS)
- start  in  1  one-cycle start pulse
- abort  in  1  synchronous abort
- conv_reset_n  out  1  to conv CU Reset_top
- conv_load_req  out  1  to conv CU Load_kernel_BRAM
- conv_chan_choose  out  2  to conv CU CHANNEL_SIZE_choose
- conv_img_choose  out  3  to conv CU IMAGE_SIZE_choose
- conv_slave_select  in  1  from conv CU; low = kernel load accepted
- conv_done  in  1  conv CU conv_DONE pulse
- wb_start  out  1  one-cycle writeback trigger
- wb_done  in  1  writeback complete pulse
- layer_idx  out  LAYER_W  current layer
- outch_idx  out  9  current output channel
- busy  out  1  sequence in progress
- seq_done  out  1  one-cycle completion pulse
- wdog_err  out  1  sticky watchdog error (0 when macro absent)

Behaviour:
Reset values and configuration:
- rst: state IDLE; conv_reset_n=0, conv_load_req=0, wb_start=0, busy=0, seq_done=0, wdog_err=0, layer_idx=0, outch_idx=0.
- Table entries clear to 0.
- cfg_we is honoured only in IDLE; it is ignored while busy=1.
- conv_chan_choose and conv_img_choose are registered from the table entry at layer_idx. They are loaded in LAYER_CFG and stay stable for the whole layer.

States:
- IDLE: conv_reset_n=0.
  - start with num_layers==0 -> seq_done pulses next cycle; no conv activity.
  - start with num_layers!=0 -> LAYER_CFG; busy=1 from the next cycle.
- LAYER_CFG (1 cycle): latch entry, outch_idx=0, conv_reset_n=0 -> CH_START.
- CH_START: conv_reset_n=1, conv_load_req=1.
  - conv_load_req is held until conv_slave_select==0 is sampled, then drops in the following cycle -> WAIT_CONV.
- WAIT_CONV: wait for conv_done -> WB_START.
- WB_START (1 cycle): wb_start=1 -> WAIT_WB.
- WAIT_WB: on wb_done:
  - if outch_idx==out_ch_m1 -> NEXT_LAYER;
  - else outch_idx+1 -> CH_START.
  - The conv CU has already returned to its own reset/idle via its Done path, so no reset pulse is needed between channels.
- NEXT_LAYER (1 cycle):
  - if layer_idx==num_layers-1 -> DONE;
  - else layer_idx+1 -> LAYER_CFG (one-cycle conv_reset_n=0 before the size change).
- DONE (1 cycle): seq_done=1, busy=0 next cycle -> IDLE; layer_idx/outch_idx hold their final values.

Timing and boundaries:
- Latency start -> first conv_load_req = 2 cycles.
- abort in any non-IDLE state -> IDLE next cycle:
  - conv_reset_n=0, conv_load_req=0, no seq_done.
  - An in-flight wb_done is dropped.
- abort has priority over every simultaneous event. rst has priority over abort.
- start while busy is ignored.
- conv_done or wb_done outside its wait state is ignored.
- conv_done and conv_slave_select==0 in the same cycle in CH_START: the acceptance is taken; conv_done is ignored.
- num_layers > MAX_LAYERS saturates to MAX_LAYERS.
- out_ch_m1=0 gives one output channel; 511 gives 512 channels.

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- Defined:
  - A counter resets on every state change and counts in CH_START, WAIT_CONV and WAIT_WB.
  - Reaching WDOG_CYCLES sets wdog_err (sticky; cleared only by rst or by the next start) and forces the abort path.
- Undefined: no counter; wdog_err is tied to 0; waits are unbounded.

Decomposition:
- Package gan_seq_pkg holds:
  - state encoding constants;
  - cfg_data field offsets and widths;
  - choose-code constants (CH_256=0, CH_128=1, CH_64=2, IMG_4=0 … IMG_128=5).
- One sub-module, gan_layer_cfg_table: the register file with its write port and a combinational read at layer_idx.
- The FSM, counters and watchdog stay in the top module.

Test Plan:
- Single layer, out_ch_m1=2, chan 64/img 4: exactly 3 conv_load_req handshakes and 3 wb_start pulses, outch_idx 0->1->2, one seq_done, busy low afterwards.
- Two layers (img 8 then img 16): conv_img_choose changes only after a 1-cycle conv_reset_n=0 between the layers; layer_idx 0->1.
- conv_slave_select held high for 10 cycles after the request: conv_load_req stays high for all 10 cycles and drops the cycle after slave_select goes low.
- abort asserted in WAIT_WB on layer 1, channel 5: IDLE next cycle, conv_reset_n=0, no seq_done; a later wb_done is ignored; a new start runs cleanly from layer 0.
- num_layers=0 with start: seq_done 1 cycle later, no conv_load_req; cfg_we during busy leaves the table unchanged.
- SEQ_WATCHDOG_EN with WDOG_CYCLES=16 and conv_done never asserted: wdog_err=1 after 16 cycles in WAIT_CONV, state IDLE; the next start clears wdog_err.

Source files
------------

// File: rtl/gan_seq_pkg.sv
// gan_seq_pkg: shared definitions for the GAN layer sequencer.
//   - sequencer state encoding
//   - layer config word field offsets/widths and an unpack helper
//   - conv CU size-select codes
package gan_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAYER_CFG  = 3'd1,
    ST_CH_START   = 3'd2,
    ST_WAIT_CONV  = 3'd3,
    ST_WB_START   = 3'd4,
    ST_WAIT_WB    = 3'd5,
    ST_NEXT_LAYER = 3'd6,
    ST_DONE       = 3'd7
  } seq_state_t;

  localparam int CFG_W        = 16;
  localparam int CFG_CHAN_LSB = 0;
  localparam int CFG_CHAN_W   = 2;
  localparam int CFG_IMG_LSB  = 2;
  localparam int CFG_IMG_W    = 3;
  localparam int CFG_OCH_LSB  = 5;
  localparam int CFG_OCH_W    = 9;
  localparam int CFG_RSVD_LSB = 14;
  localparam int CFG_RSVD_W   = 2;

  localparam logic [1:0] CH_256 = 2'd0;
  localparam logic [1:0] CH_128 = 2'd1;
  localparam logic [1:0] CH_64  = 2'd2;

  localparam logic [2:0] IMG_4   = 3'd0;
  localparam logic [2:0] IMG_8   = 3'd1;
  localparam logic [2:0] IMG_16  = 3'd2;
  localparam logic [2:0] IMG_32  = 3'd3;
  localparam logic [2:0] IMG_64  = 3'd4;
  localparam logic [2:0] IMG_128 = 3'd5;

  typedef struct packed {
    logic [CFG_RSVD_W-1:0] rsvd;
    logic [CFG_OCH_W-1:0]  out_ch_m1;
    logic [CFG_IMG_W-1:0]  img;
    logic [CFG_CHAN_W-1:0] chan;
  } cfg_entry_t;

  function automatic cfg_entry_t unpack_cfg(input logic [CFG_W-1:0] raw);
    cfg_entry_t e;
    e.rsvd      = raw[CFG_RSVD_LSB +: CFG_RSVD_W];
    e.out_ch_m1 = raw[CFG_OCH_LSB +: CFG_OCH_W];
    e.img       = raw[CFG_IMG_LSB +: CFG_IMG_W];
    e.chan      = raw[CFG_CHAN_LSB +: CFG_CHAN_W];
    return e;
  endfunction

endpackage

// File: rtl/gan_layer_cfg_table.sv
// gan_layer_cfg_table: layer configuration register file.
// Ports:
//   clk, rst      system clock, synchronous active-high reset (clears all entries)
//   we/waddr/wdata write port (caller gates we to the idle state)
//   raddr/rdata    combinational read port
module gan_layer_cfg_table
  import gan_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [CFG_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [CFG_W-1:0] rdata
);

  logic [CFG_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gan_layer_sequencer.sv
// gan_layer_sequencer: layer-level scheduler above the conv2d control unit.
// Runs every output channel of every configured layer: conv pass (kernel
// load handshake + conv_done wait) followed by a writeback pass.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data          layer table write (idle only)
//   num_layers, start, abort          sequence control
//   conv_reset_n, conv_load_req,
//   conv_chan_choose, conv_img_choose to conv CU
//   conv_slave_select, conv_done      from conv CU
//   wb_start / wb_done                writeback handshake
//   layer_idx, outch_idx, busy,
//   seq_done, wdog_err                status
// Optional build macro SEQ_WATCHDOG_EN adds a per-wait-state watchdog;
// without it wdog_err is tied low and waits are unbounded.
//
// state      | meaning
// IDLE       | conv CU held in reset, waiting for start
// LAYER_CFG  | latch table entry for layer_idx, conv CU held in reset
// CH_START   | kernel-load request until conv CU accepts (slave_select low)
// WAIT_CONV  | waiting for conv_done
// WB_START   | one-cycle writeback trigger
// WAIT_WB    | waiting for wb_done, then next channel or next layer
// NEXT_LAYER | advance layer or finish
// DONE       | seq_done pulse
module gan_layer_sequencer
  import gan_seq_pkg::*;
#(
  parameter int MAX_LAYERS  = 8,
  parameter int LAYER_W     = 3,
  parameter int WDOG_CYCLES = 1 << 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [LAYER_W-1:0] cfg_addr,
  input  logic [15:0]        cfg_data,
  input  logic [LAYER_W:0]   num_layers,
  input  logic               start,
  input  logic               abort,
  output logic               conv_reset_n,
  output logic               conv_load_req,
  output logic [1:0]         conv_chan_choose,
  output logic [2:0]         conv_img_choose,
  input  logic               conv_slave_select,
  input  logic               conv_done,
  output logic               wb_start,
  input  logic               wb_done,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [8:0]         outch_idx,
  output logic               busy,
  output logic               seq_done,
  output logic               wdog_err
);

  seq_state_t         state, next_state;
  logic [CFG_W-1:0]   entry_raw;
  cfg_entry_t         entry;
  logic [LAYER_W:0]   nl_sat;
  logic [LAYER_W-1:0] last_layer;
  logic [8:0]         out_ch_m1_q;
  logic               empty_run;
  logic               accept_start;
  logic               wdog_trip;
  logic               abort_any;
  logic               unused_rsvd;

  gan_layer_cfg_table #(
    .DEPTH(MAX_LAYERS),
    .AW   (LAYER_W)
  ) u_cfg_table (
    .clk  (clk),
    .rst  (rst),
    .we   (cfg_we && (state == ST_IDLE)),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .raddr(layer_idx),
    .rdata(entry_raw)
  );

  assign entry       = unpack_cfg(entry_raw);
  assign unused_rsvd = ^entry.rsvd;

  assign nl_sat = (num_layers > (LAYER_W+1)'(MAX_LAYERS)) ? (LAYER_W+1)'(MAX_LAYERS)
                                                           : num_layers;
  // abort in idle also swallows a coincident start
  assign accept_start = (state == ST_IDLE) && start && !abort;
  assign abort_any    = abort || wdog_trip;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort_any && (state != ST_IDLE)) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:       if (accept_start)
                         next_state = (num_layers == '0) ? ST_DONE : ST_LAYER_CFG;
        ST_LAYER_CFG:  next_state = ST_CH_START;
        // acceptance wins; a coincident conv_done is not looked at here
        ST_CH_START:   if (!conv_slave_select) next_state = ST_WAIT_CONV;
        ST_WAIT_CONV:  if (conv_done) next_state = ST_WB_START;
        ST_WB_START:   next_state = ST_WAIT_WB;
        ST_WAIT_WB:    if (wb_done)
                         next_state = (outch_idx == out_ch_m1_q) ? ST_NEXT_LAYER : ST_CH_START;
        ST_NEXT_LAYER: next_state = (layer_idx == last_layer) ? ST_DONE : ST_LAYER_CFG;
        ST_DONE:       next_state = ST_IDLE;
        default:       next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    conv_reset_n  = 1'b0;
    conv_load_req = 1'b0;
    wb_start      = 1'b0;
    seq_done      = 1'b0;
    busy          = 1'b1;
    unique case (state)
      ST_IDLE:       busy = 1'b0;
      ST_LAYER_CFG:  conv_reset_n = 1'b0;
      ST_CH_START:   begin conv_reset_n = 1'b1; conv_load_req = 1'b1; end
      ST_WAIT_CONV:  conv_reset_n = 1'b1;
      ST_WB_START:   begin conv_reset_n = 1'b1; wb_start = 1'b1; end
      ST_WAIT_WB:    conv_reset_n = 1'b1;
      ST_NEXT_LAYER: conv_reset_n = 1'b1;
      // a zero-layer run never raises busy, not even in its DONE cycle
      ST_DONE:       begin seq_done = 1'b1; busy = !empty_run; end
      default:       busy = 1'b0;
    endcase
  end

  // Sizes are latched at the end of LAYER_CFG, so they only change while the
  // conv CU comes out of the one-cycle reset that LAYER_CFG provides.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_idx        <= '0;
      outch_idx        <= '0;
      last_layer       <= '0;
      out_ch_m1_q      <= '0;
      empty_run        <= 1'b0;
      conv_chan_choose <= '0;
      conv_img_choose  <= '0;
    end else begin
      if (accept_start) begin
        layer_idx  <= '0;
        outch_idx  <= '0;
        last_layer <= LAYER_W'(nl_sat - (LAYER_W+1)'(1));
        empty_run  <= (num_layers == '0);
      end
      if (state == ST_LAYER_CFG) begin
        outch_idx        <= '0;
        out_ch_m1_q      <= entry.out_ch_m1;
        conv_chan_choose <= entry.chan;
        conv_img_choose  <= entry.img;
      end
      if ((state == ST_WAIT_WB) && (next_state == ST_CH_START))
        outch_idx <= outch_idx + 9'd1;
      if ((state == ST_NEXT_LAYER) && (next_state == ST_LAYER_CFG))
        layer_idx <= layer_idx + LAYER_W'(1);
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_err_q;
  logic              in_wait;

  assign in_wait   = (state == ST_CH_START) || (state == ST_WAIT_CONV) ||
                     (state == ST_WAIT_WB);
  // count value k means the (k+1)-th cycle in the current wait state
  assign wdog_trip = in_wait && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (!in_wait || (state != next_state)) wdog_cnt <= '0;
      else                                   wdog_cnt <= wdog_cnt + WDOG_W'(1);
      if (accept_start)   wdog_err_q <= 1'b0;
      else if (wdog_trip) wdog_err_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_gan_layer_sequencer.sv
// Table-driven bench for gan_layer_sequencer with a scoreboard of expected
// (layer, channel, size selects) tuples checked at every wb_start pulse.
module tb_gan_layer_sequencer;
  import gan_seq_pkg::*;

  localparam int MAXL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [3:0]  num_layers;
  logic        start, abort;
  logic        conv_reset_n, conv_load_req;
  logic [1:0]  conv_chan_choose;
  logic [2:0]  conv_img_choose;
  logic        conv_slave_select, conv_done;
  logic        wb_start, wb_done;
  logic [2:0]  layer_idx;
  logic [8:0]  outch_idx;
  logic        busy, seq_done, wdog_err;

  gan_layer_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .num_layers(num_layers), .start(start), .abort(abort),
    .conv_reset_n(conv_reset_n), .conv_load_req(conv_load_req),
    .conv_chan_choose(conv_chan_choose), .conv_img_choose(conv_img_choose),
    .conv_slave_select(conv_slave_select), .conv_done(conv_done),
    .wb_start(wb_start), .wb_done(wb_done), .layer_idx(layer_idx), .outch_idx(outch_idx),
    .busy(busy), .seq_done(seq_done), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] layer;
    logic [8:0] ch;
    logic [1:0] chan;
    logic [2:0] img;
  } sb_t;

  typedef struct {
    string       name;
    int          nl;
    int          ss_hold;
    logic        stray;
    logic        wr_busy;
    logic        rewrite;
    logic [15:0] e0, e1, fill;
    int          exp_wb;
    int          exp_done;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  sb_t         sb_q[$];
  logic [15:0] shadow[MAXL];
  vec_t        vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_cfg(input int och, input logic [2:0] img, input logic [1:0] chan);
    return {2'b00, 9'(och), img, chan};
  endfunction

  function automatic vec_t mk_vec(input string name, input int nl, input int ss_hold,
                                  input logic stray, input logic wr_busy, input logic rewrite,
                                  input logic [15:0] e0, input logic [15:0] e1,
                                  input logic [15:0] fill, input int exp_wb, input int exp_done);
    vec_t v;
    v.name = name; v.nl = nl; v.ss_hold = ss_hold; v.stray = stray; v.wr_busy = wr_busy;
    v.rewrite = rewrite; v.e0 = e0; v.e1 = e1; v.fill = fill;
    v.exp_wb = exp_wb; v.exp_done = exp_done;
    return v;
  endfunction

  task automatic write_table(input vec_t v);
    for (int i = 0; i < MAXL; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 3'(i);
      cfg_data = (i == 0) ? v.e0 : (i == 1) ? v.e1 : v.fill;
      @(posedge clk); #1;
      shadow[i] = cfg_data;
    end
    cfg_we = 1'b0;
  endtask

  task automatic run_seq(input vec_t v, input int ab_layer, input int ab_ch);
    int n, wb_cnt, done_cnt, acc_cnt, first_req, done_n, req_run, run_min, run_max;
    int conv_t, wb_t, rst_viol, wr_cnt, ab_arm, pushed, nl_eff, bad_post;
    logic conv_ok, prev_rst_n, finished, busy_seen;
    logic [1:0] prev_chan;
    logic [2:0] prev_img;
    logic [15:0] e;
    sb_t got, exp;

    if (v.rewrite) write_table(v);
    nl_eff = (v.nl > MAXL) ? MAXL : v.nl;
    pushed = 0;
    for (int l = 0; l < nl_eff; l++) begin
      e = shadow[l];
      for (int c = 0; c <= int'(e[13:5]); c++) begin
        sb_q.push_back('{layer: 3'(l), ch: 9'(c), chan: e[1:0], img: e[4:2]});
        pushed++;
      end
    end

    wb_cnt = 0; done_cnt = 0; acc_cnt = 0; first_req = -1; done_n = -1; req_run = 0;
    run_min = 1 << 30; run_max = 0; conv_t = 0; wb_t = 0; rst_viol = 0; wr_cnt = 0;
    ab_arm = 0; conv_ok = 1'b0; finished = 1'b0; busy_seen = 1'b0;
    prev_chan = conv_chan_choose; prev_img = conv_img_choose; prev_rst_n = conv_reset_n;

    num_layers = 4'(v.nl);
    start      = 1'b1;
    for (n = 1; n <= 20000 && !finished; n++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; conv_done = 1'b0; wb_done = 1'b0;
      conv_slave_select = 1'b1; cfg_we = 1'b0;
      if (busy) busy_seen = 1'b1;
      if (((conv_chan_choose !== prev_chan) || (conv_img_choose !== prev_img)) && prev_rst_n)
        rst_viol++;
      prev_chan = conv_chan_choose; prev_img = conv_img_choose; prev_rst_n = conv_reset_n;
      if (conv_load_req) begin
        if (first_req < 0) first_req = n;
        req_run++;
      end else if (req_run > 0) begin
        if (req_run < run_min) run_min = req_run;
        if (req_run > run_max) run_max = req_run;
        req_run = 0;
      end

      if (ab_arm == 2) begin
        check({v.name, ".abort_busy"}, int'(busy), 0);
        check({v.name, ".abort_rst_n"}, int'(conv_reset_n), 0);
        check({v.name, ".abort_req"}, int'(conv_load_req), 0);
        check({v.name, ".abort_seq_done"}, int'(seq_done), 0);
        finished = 1'b1;
      end else begin
        if (conv_t > 0) begin
          conv_t--;
          if (conv_t == 0) begin conv_done = 1'b1; conv_ok = 1'b1; end
        end
        if (wb_t > 0) begin
          wb_t--;
          if (wb_t == 0) wb_done = 1'b1;
        end
        if (ab_arm == 1) begin
          abort = 1'b1; wb_done = 1'b1; ab_arm = 2;
        end
        if (conv_load_req && (req_run > v.ss_hold)) begin
          conv_slave_select = 1'b0;
          acc_cnt++;
          conv_t  = 3;
          conv_ok = 1'b0;
          if (v.stray) begin conv_done = 1'b1; wb_done = 1'b1; end
        end
        if (wb_start) begin
          wb_cnt++;
          check({v.name, ".conv_before_wb"}, int'(conv_ok), 1);
          conv_ok = 1'b0;
          got = '{layer: layer_idx, ch: outch_idx, chan: conv_chan_choose, img: conv_img_choose};
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s.sb_underflow actual=%0h required=none", v.name, got);
          end else begin
            exp = sb_q.pop_front();
            check({v.name, ".sb_tuple"}, int'(got), int'(exp));
          end
          if ((int'(layer_idx) == ab_layer) && (int'(outch_idx) == ab_ch)) begin
            ab_arm = 1; wb_t = 0;
          end else begin
            wb_t = 2;
          end
        end
        if (v.wr_busy && busy && (wr_cnt < 2)) begin
          cfg_we = 1'b1; cfg_addr = 3'(wr_cnt); cfg_data = 16'hFFFF; wr_cnt++;
        end
        if (seq_done) begin
          done_cnt++; done_n = n; finished = 1'b1;
        end
      end
    end
    conv_done = 1'b0; wb_done = 1'b0; cfg_we = 1'b0; conv_slave_select = 1'b1;

    if (!finished) begin
      checks++; errors++;
      $display("FAIL %s.timeout actual=unfinished required=finished", v.name);
    end

    if (ab_arm == 2) begin
      bad_post = 0;
      repeat (4) begin
        conv_done = 1'b1; wb_done = 1'b1; conv_slave_select = 1'b0;
        @(posedge clk); #1;
        if (busy || wb_start || conv_load_req || seq_done) bad_post++;
      end
      conv_done = 1'b0; wb_done = 1'b0; conv_slave_select = 1'b1;
      check({v.name, ".post_abort_quiet"}, bad_post, 0);
    end else begin
      @(posedge clk); #1;
      check({v.name, ".busy_after"}, int'(busy), 0);
      check({v.name, ".done_width"}, int'(seq_done), 0);
    end

    check({v.name, ".wb_count"}, wb_cnt, v.exp_wb);
    check({v.name, ".handshakes"}, acc_cnt, v.exp_wb);
    check({v.name, ".done_count"}, done_cnt, v.exp_done);
    check({v.name, ".sb_left"}, sb_q.size(), pushed - v.exp_wb);
    check({v.name, ".reset_before_size"}, rst_viol, 0);
    check({v.name, ".first_req"}, first_req, (v.nl != 0) ? 2 : -1);
    check({v.name, ".busy_seen"}, int'(busy_seen), (v.nl != 0) ? 1 : 0);
    check({v.name, ".wdog_err"}, int'(wdog_err), 0);
    if (v.nl == 0) check({v.name, ".done_latency"}, done_n, 1);
    if (v.exp_wb > 0) begin
      check({v.name, ".req_run_min"}, run_min, v.ss_hold + 1);
      check({v.name, ".req_run_max"}, run_max, v.ss_hold + 1);
    end
    sb_q.delete();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; num_layers = '0;
    start = 1'b0; abort = 1'b0; conv_slave_select = 1'b1; conv_done = 1'b0; wb_done = 1'b0;
    for (int i = 0; i < MAXL; i++) shadow[i] = '0;

    vecs[0] = mk_vec("reset_table", 1, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1, 1);
    vecs[1] = mk_vec("single_3ch", 1, 0, 1'b0, 1'b0, 1'b1,
                     mk_cfg(2, IMG_4, CH_64), 16'h0, 16'h0, 3, 1);
    vecs[2] = mk_vec("two_layer", 2, 0, 1'b0, 1'b0, 1'b1,
                     mk_cfg(1, IMG_8, CH_128), mk_cfg(0, IMG_16, CH_256), 16'h0, 3, 1);
    vecs[3] = mk_vec("ss_hold10", 1, 10, 1'b0, 1'b0, 1'b1,
                     mk_cfg(1, IMG_32, CH_64), 16'h0, 16'h0, 2, 1);
    vecs[4] = mk_vec("stray_pulses", 1, 0, 1'b1, 1'b0, 1'b1,
                     mk_cfg(3, IMG_128, CH_128), 16'h0, 16'h0, 4, 1);
    vecs[5] = mk_vec("cfg_we_busy", 2, 2, 1'b0, 1'b1, 1'b1,
                     mk_cfg(1, IMG_8, CH_128), mk_cfg(0, IMG_16, CH_256), 16'h0, 3, 1);
    vecs[6] = mk_vec("table_kept", 2, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3, 1);
    vecs[7] = mk_vec("zero_layers", 0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 0, 1);
    vecs[8] = mk_vec("saturate_15", 15, 0, 1'b0, 1'b0, 1'b1,
                     mk_cfg(0, IMG_64, CH_256), mk_cfg(0, IMG_64, CH_128),
                     mk_cfg(0, IMG_64, CH_256), 8, 1);
    vecs[9] = mk_vec("och_511", 1, 0, 1'b0, 1'b0, 1'b1,
                     mk_cfg(511, IMG_8, CH_256), 16'h0, 16'h0, 512, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst.conv_reset_n", int'(conv_reset_n), 0);
    check("rst.conv_load_req", int'(conv_load_req), 0);
    check("rst.wb_start", int'(wb_start), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.seq_done", int'(seq_done), 0);
    check("rst.wdog_err", int'(wdog_err), 0);
    check("rst.layer_idx", int'(layer_idx), 0);
    check("rst.outch_idx", int'(outch_idx), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle.busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) run_seq(vecs[i], -1, -1);

    run_seq(mk_vec("abort_l1c5", 2, 0, 1'b0, 1'b0, 1'b1,
                   mk_cfg(1, IMG_8, CH_128), mk_cfg(7, IMG_16, CH_64), 16'h0, 8, 0), 1, 5);
    run_seq(mk_vec("after_abort", 2, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 10, 1), -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
